// File: rtl/cam_pkg.sv
// Shared types and default widths for the CAM command-side controller.
package cam_pkg;

  localparam int unsigned CamDwDefault      = 32;
  localparam int unsigned CamMwDefault      = 3;
  localparam int unsigned CamAwDefault      = 8;
  localparam int unsigned TimeoutCycDefault = 16;

  typedef enum logic [1:0] {
    OpWrite  = 2'd0,
    OpMask   = 2'd1,
    OpSearch = 2'd2,
    OpRsvd   = 2'd3
  } cam_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StMask,
    StSrch,
    StAck,
    StResp
  } cam_req_state_e;

endpackage

// File: rtl/cam_req_timer.sv
// Saturating search-wait counter; expired_o flags the last allowed wait cycle.
module cam_req_timer #(
  parameter int unsigned TimeoutCyc = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutCyc + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCyc - 1);
  localparam logic [CntW-1:0] SatCnt  = CntW'(TimeoutCyc);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SatCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/cam_requester.sv
// Command-side CAM controller: write / mask / search with one response per command.
// Search timeout is built only when CAM_REQ_TIMEOUT_EN is defined.
module cam_requester
  import cam_pkg::*;
#(
  parameter int unsigned CAM_DW      = CamDwDefault,
  parameter int unsigned CAM_MW      = CamMwDefault,
  parameter int unsigned CAM_AW      = CamAwDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CAM_DW-1:0] cmd_data,
  input  logic [CAM_AW-1:0] cmd_addr,
  input  logic [CAM_MW-1:0] cmd_mask,
  input  logic [CAM_MW-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_timeout,
  output logic [CAM_DW-1:0] rsp_data,
  output logic [CAM_AW-1:0] rsp_addr,
  output logic [CAM_DW-1:0] data_in,
  output logic [CAM_AW-1:0] addr_in,
  output logic              input_valid,
  output logic [CAM_MW-1:0] mask_in,
  output logic [CAM_MW-1:0] mask_strb,
  input  logic              hit,
  input  logic [CAM_DW-1:0] data_out,
  input  logic [CAM_AW-1:0] addr_out,
  output logic              data_valid
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  cam_req_state_e state_q, state_d;

  logic              cmd_ready_q, input_valid_q, data_valid_q, rsp_valid_q;
  logic              rsp_hit_q, rsp_hit_d;
  logic [CAM_DW-1:0] rsp_data_q, rsp_data_d;
  logic [CAM_AW-1:0] rsp_addr_q, rsp_addr_d;
  logic [CAM_DW-1:0] data_in_q, data_in_d;
  logic [CAM_AW-1:0] addr_in_q, addr_in_d;
  logic [CAM_MW-1:0] mask_in_q, mask_in_d;
  logic [CAM_MW-1:0] mask_strb_q, mask_strb_d;

  logic    accept;
  cam_op_e op;
  logic    tmr_expired;

  assign accept = cmd_valid && cmd_ready_q;
  assign op     = cam_op_e'(cmd_op);

  always_comb begin
    state_d     = state_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    data_in_d   = data_in_q;
    addr_in_d   = addr_in_q;
    mask_in_d   = mask_in_q;
    mask_strb_d = mask_strb_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // A timed-out search must report zero data, so clear on every accept.
          rsp_data_d = '0;
          rsp_addr_d = '0;
          unique case (op)
            OpWrite: begin
              state_d   = StWrite;
              data_in_d = cmd_data;
              addr_in_d = cmd_addr;
            end
            OpMask: begin
              state_d     = StMask;
              mask_in_d   = cmd_mask;
              mask_strb_d = cmd_strb;
            end
            OpSearch: begin
              state_d   = StSrch;
              data_in_d = cmd_data;
            end
            OpRsvd: state_d = StResp;
          endcase
        end
      end
      StWrite, StMask, StAck: state_d = StResp;
      StSrch: begin
        if (hit) begin
          state_d    = StAck;
          rsp_hit_d  = 1'b1;
          rsp_data_d = data_out;
          rsp_addr_d = addr_out;
        end else if (tmr_expired) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d   = StIdle;
          rsp_hit_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      input_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_addr_q    <= '0;
      data_in_q     <= '0;
      addr_in_q     <= '0;
      mask_in_q     <= '0;
      mask_strb_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= (state_d == StIdle);
      input_valid_q <= (state_d == StWrite);
      data_valid_q  <= (state_d == StAck);
      rsp_valid_q   <= (state_d == StResp);
      rsp_hit_q     <= rsp_hit_d;
      rsp_data_q    <= rsp_data_d;
      rsp_addr_q    <= rsp_addr_d;
      data_in_q     <= data_in_d;
      addr_in_q     <= addr_in_d;
      mask_in_q     <= mask_in_d;
      mask_strb_q   <= mask_strb_d;
    end
  end

`ifdef CAM_REQ_TIMEOUT_EN
  logic rsp_timeout_q;

  cam_req_timer #(
    .TimeoutCyc(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept && (op == OpSearch)),
    .en_i     (state_q == StSrch),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_timeout_q <= 1'b0;
    end else if ((state_q == StSrch) && !hit && tmr_expired) begin
      rsp_timeout_q <= 1'b1;
    end else if ((state_q == StResp) && rsp_ready) begin
      rsp_timeout_q <= 1'b0;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign tmr_expired = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign input_valid = input_valid_q;
  assign data_valid  = data_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;
  assign data_in     = data_in_q;
  assign addr_in     = addr_in_q;
  assign mask_in     = mask_in_q;
  assign mask_strb   = mask_strb_q;

endmodule

// File: tb/tb_cam_requester.sv
// Directed table-driven bench for cam_requester plus backpressure and reset sequences.
module tb_cam_requester;
  import cam_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] cmd_addr;
  logic [MW-1:0] cmd_mask, cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr_in;
  logic          input_valid;
  logic [MW-1:0] mask_in, mask_strb;
  logic          hit;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_out;
  logic          data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  cam_requester #(
    .CAM_DW     (DW),
    .CAM_MW     (MW),
    .CAM_AW     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_addr   (cmd_addr),
    .cmd_mask   (cmd_mask),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_timeout(rsp_timeout),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .input_valid(input_valid),
    .mask_in    (mask_in),
    .mask_strb  (mask_strb),
    .hit        (hit),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .data_valid (data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, expected test completion");
    $fatal(1, "bench did not complete");
  end

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [MW-1:0] strb;
    int            hit_wait;   // wait cycle in which hit pulses; 0 = never
    bit            hit_stuck;  // hold hit high for the whole command
    logic [DW-1:0] cam_data;
    logic [AW-1:0] cam_addr;
    int            exp_lat;    // cycles from accept edge to first rsp_valid
    int            exp_iv;
    int            exp_dv;
    bit            exp_hit;
    bit            exp_to;
    bit            chk_rsp;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_addr;
    logic [MW-1:0] exp_mask;
    logic [MW-1:0] exp_strb;
  } vec_t;

  function automatic vec_t mk(
    logic [1:0] op, logic [DW-1:0] d, logic [AW-1:0] a, logic [MW-1:0] m, logic [MW-1:0] s,
    int hw, bit hs, logic [DW-1:0] cd, logic [AW-1:0] ca, int lat, int iv, int dv, bit eh,
    bit et, bit cr, logic [DW-1:0] ed, logic [AW-1:0] ea, logic [MW-1:0] em, logic [MW-1:0] es);
    vec_t v;
    v.op = op; v.data = d; v.addr = a; v.mask = m; v.strb = s;
    v.hit_wait = hw; v.hit_stuck = hs; v.cam_data = cd; v.cam_addr = ca;
    v.exp_lat = lat; v.exp_iv = iv; v.exp_dv = dv; v.exp_hit = eh; v.exp_to = et;
    v.chk_rsp = cr; v.exp_data = ed; v.exp_addr = ea; v.exp_mask = em; v.exp_strb = es;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".cmd_ready"}, 0, 64'(cmd_ready), 64'd0);
    chk({name, ".rsp_valid"}, 0, 64'(rsp_valid), 64'd0);
    chk({name, ".rsp_hit"}, 0, 64'(rsp_hit), 64'd0);
    chk({name, ".rsp_timeout"}, 0, 64'(rsp_timeout), 64'd0);
    chk({name, ".rsp_data"}, 0, 64'(rsp_data), 64'd0);
    chk({name, ".rsp_addr"}, 0, 64'(rsp_addr), 64'd0);
    chk({name, ".data_in"}, 0, 64'(data_in), 64'd0);
    chk({name, ".addr_in"}, 0, 64'(addr_in), 64'd0);
    chk({name, ".input_valid"}, 0, 64'(input_valid), 64'd0);
    chk({name, ".mask_in"}, 0, 64'(mask_in), 64'd0);
    chk({name, ".mask_strb"}, 0, 64'(mask_strb), 64'd0);
    chk({name, ".data_valid"}, 0, 64'(data_valid), 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int iv_cnt = 0;
    int dv_cnt = 0;
    int lat    = 0;
    @(negedge clk);
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_addr  = v.addr;
    cmd_mask  = v.mask;
    cmd_strb  = v.strb;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    hit       = v.hit_stuck;
    data_out  = ~v.cam_data;
    addr_out  = ~v.cam_addr;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_before", idx, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (input_valid) begin
        iv_cnt++;
        chk("data_in_write", idx, 64'(data_in), 64'(v.data));
        chk("addr_in_write", idx, 64'(addr_in), 64'(v.addr));
      end
      if (data_valid) dv_cnt++;
      if (v.op == OpSearch && c == 1) chk("data_in_key", idx, 64'(data_in), 64'(v.data));
      if (rsp_valid) begin
        lat = c;
      end else begin
        hit      = v.hit_stuck || (c == v.hit_wait);
        data_out = (c == v.hit_wait) ? v.cam_data : ~v.cam_data;
        addr_out = (c == v.hit_wait) ? v.cam_addr : ~v.cam_addr;
      end
    end
    chk("rsp_latency", idx, 64'(lat), 64'(v.exp_lat));
    chk("input_valid_pulses", idx, 64'(iv_cnt), 64'(v.exp_iv));
    chk("data_valid_pulses", idx, 64'(dv_cnt), 64'(v.exp_dv));
    chk("rsp_hit", idx, 64'(rsp_hit), 64'(v.exp_hit));
    chk("rsp_timeout", idx, 64'(rsp_timeout), 64'(v.exp_to));
    chk("cmd_ready_busy", idx, 64'(cmd_ready), 64'd0);
    if (v.chk_rsp) begin
      chk("rsp_data", idx, 64'(rsp_data), 64'(v.exp_data));
      chk("rsp_addr", idx, 64'(rsp_addr), 64'(v.exp_addr));
    end
    @(negedge clk);
    chk("rsp_valid_after", idx, 64'(rsp_valid), 64'd0);
    chk("rsp_hit_after", idx, 64'(rsp_hit), 64'd0);
    chk("cmd_ready_after", idx, 64'(cmd_ready), 64'd1);
    chk("mask_in", idx, 64'(mask_in), 64'(v.exp_mask));
    chk("mask_strb", idx, 64'(mask_strb), 64'(v.exp_strb));
    hit = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_addr  = '0;
    cmd_mask  = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    hit       = 1'b0;
    data_out  = '0;
    addr_out  = '0;

    //            op        data          addr   mask    strb    hw  hs cam_data      cam_addr
    //            lat iv dv hit to chk exp_data     exp_addr emask   estrb
    vecs[0] = mk(OpWrite, 32'hFFFF_FFFF, 8'h01, 3'b000, 3'b000, 0, 0, 32'h0, 8'h0,
                 2, 1, 0, 0, 0, 0, 32'h0, 8'h0, 3'b000, 3'b000);
    vecs[1] = mk(OpMask, 32'h0, 8'h0, 3'b111, 3'b111, 0, 0, 32'h0, 8'h0,
                 2, 0, 0, 0, 0, 0, 32'h0, 8'h0, 3'b111, 3'b111);
    vecs[2] = mk(OpSearch, 32'hFFFF_FFFF, 8'h0, 3'b000, 3'b000, 3, 0, 32'hFFFF_FFFF, 8'h01,
                 5, 0, 1, 1, 0, 1, 32'hFFFF_FFFF, 8'h01, 3'b111, 3'b111);
    vecs[3] = mk(OpWrite, 32'h1234_5678, 8'hA5, 3'b000, 3'b000, 0, 1, 32'h0, 8'h0,
                 2, 1, 0, 0, 0, 0, 32'h0, 8'h0, 3'b111, 3'b111);
    vecs[4] = mk(OpRsvd, 32'h0, 8'h0, 3'b000, 3'b000, 0, 0, 32'h0, 8'h0,
                 1, 0, 0, 0, 0, 0, 32'h0, 8'h0, 3'b111, 3'b111);
    vecs[5] = mk(OpSearch, 32'hDEAD_BEEF, 8'h0, 3'b000, 3'b000, 1, 0, 32'hCAFE_F00D, 8'h7E,
                 3, 0, 1, 1, 0, 1, 32'hCAFE_F00D, 8'h7E, 3'b111, 3'b111);
    vecs[6] = mk(OpMask, 32'h0, 8'h0, 3'b010, 3'b101, 0, 0, 32'h0, 8'h0,
                 2, 0, 0, 0, 0, 0, 32'h0, 8'h0, 3'b010, 3'b101);
    // Hit in the last allowed wait cycle beats expiry.
    vecs[7] = mk(OpSearch, 32'h0000_0042, 8'h0, 3'b000, 3'b000, 16, 0, 32'h0BAD_CAFE, 8'hFF,
                 18, 0, 1, 1, 0, 1, 32'h0BAD_CAFE, 8'hFF, 3'b010, 3'b101);
`ifdef CAM_REQ_TIMEOUT_EN
    vecs[8] = mk(OpSearch, 32'h0000_0099, 8'h0, 3'b000, 3'b000, 0, 0, 32'h0, 8'h0,
                 17, 0, 0, 0, 1, 1, 32'h0, 8'h0, 3'b010, 3'b101);
`else
    // No timeout: a late hit still completes the search.
    vecs[8] = mk(OpSearch, 32'h0000_0099, 8'h0, 3'b000, 3'b000, 40, 0, 32'h5555_AAAA, 8'h33,
                 42, 0, 1, 1, 0, 1, 32'h5555_AAAA, 8'h33, 3'b010, 3'b101);
`endif
    // After reset the mask latch is back to zero.
    vecs[9] = mk(OpWrite, 32'h0F0F_0F0F, 8'h10, 3'b000, 3'b000, 0, 0, 32'h0, 8'h0,
                 2, 1, 0, 0, 0, 0, 32'h0, 8'h0, 3'b000, 3'b000);

    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("cmd_ready_release", 0, 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("cmd_ready_first", 0, 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Backpressure: response held for 5 cycles with a competing command waiting.
    @(negedge clk);
    cmd_op    = OpSearch;
    cmd_data  = 32'hAAAA_0001;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hit      = 1'b1;
    data_out = 32'h1357_9BDF;
    addr_out = 8'h5A;
    @(negedge clk);
    hit      = 1'b0;
    data_out = '0;
    addr_out = '0;
    @(negedge clk);
    cmd_op    = OpWrite;
    cmd_data  = 32'h0000_0077;
    cmd_addr  = 8'h44;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", i, 64'(rsp_valid), 64'd1);
      chk("bp_rsp_hit", i, 64'(rsp_hit), 64'd1);
      chk("bp_rsp_data", i, 64'(rsp_data), 64'h1357_9BDF);
      chk("bp_rsp_addr", i, 64'(rsp_addr), 64'h5A);
      chk("bp_cmd_ready", i, 64'(cmd_ready), 64'd0);
      chk("bp_input_valid", i, 64'(input_valid), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_done", 0, 64'(rsp_valid), 64'd0);
    chk("bp_cmd_ready_after", 0, 64'(cmd_ready), 64'd1);
    chk("bp_not_yet_taken", 0, 64'(input_valid), 64'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_write_iv", 0, 64'(input_valid), 64'd1);
    chk("bp_write_data", 0, 64'(data_in), 64'h77);
    chk("bp_write_addr", 0, 64'(addr_in), 64'h44);
    @(negedge clk);
    chk("bp_write_rsp", 0, 64'(rsp_valid), 64'd1);
    chk("bp_write_hit", 0, 64'(rsp_hit), 64'd0);
    @(negedge clk);

    // Reset in the middle of a search.
    cmd_op    = OpSearch;
    cmd_data  = 32'hBEEF_0002;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("srch_key_held", 0, 64'(data_in), 64'hBEEF_0002);
    chk("srch_no_rsp", 0, 64'(rsp_valid), 64'd0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_srch");
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_srch_ready_low", 0, 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("rst_srch_ready", 0, 64'(cmd_ready), 64'd1);

    // Reset while input_valid is high must drop it without a clock edge.
    cmd_op    = OpWrite;
    cmd_data  = 32'h0000_ABCD;
    cmd_addr  = 8'h22;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_wr_iv_pre", 0, 64'(input_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_wr_iv", 0, 64'(input_valid), 64'd0);
    chk("rst_wr_data", 0, 64'(data_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_ready", 0, 64'(cmd_ready), 64'd1);

    run_vec(9, vecs[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
